// File: rtl/joypad_pkg.sv
// Shared pad definitions: button bit positions, stick byte values and the
// handshake state type, used by both the transmit and the receive path.
// Pure declarations; no logic, no latency, no flow control.
package joypad_pkg;

  // Button bit positions inside cont_key[15:0]
  localparam int KEY_UP     = 0;
  localparam int KEY_DOWN   = 1;
  localparam int KEY_LEFT   = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_A      = 4;
  localparam int KEY_B      = 5;
  localparam int KEY_X      = 6;
  localparam int KEY_Y      = 7;
  localparam int KEY_L1     = 8;
  localparam int KEY_R1     = 9;
  localparam int KEY_L2     = 10;
  localparam int KEY_R2     = 11;
  localparam int KEY_L3     = 12;
  localparam int KEY_R3     = 13;
  localparam int KEY_SELECT = 14;
  localparam int KEY_START  = 15;

  // Analog stick byte values
  localparam logic [7:0] JOY_CENTER = 8'h80;
  localparam logic [7:0] JOY_MIN    = 8'h00;
  localparam logic [7:0] JOY_MAX    = 8'hFF;

  // Controller type field inside cont_key
  localparam int PAD_TYPE_LSB = 28;
  localparam int PAD_TYPE_MSB = 31;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } joypad_tx_state_t;

  // Stick target for one axis from its two opposing D-PAD buttons.
  // Both or neither pressed means the stick rests at centre.
  function automatic logic [7:0] axis_target(input logic neg, input logic pos);
    logic [7:0] tgt;
    tgt = JOY_CENTER;
    if (neg && !pos) tgt = JOY_MIN;
    if (pos && !neg) tgt = JOY_MAX;
    return tgt;
  endfunction

endpackage

// File: rtl/joypad_axis_slew.sv
// One synthesised stick axis: picks the D-PAD target and slews toward it.
// Purely combinational (0 cycles); the caller registers nxt on its tick.
// No flow control; analog_en low snaps the axis straight to centre.
//   cur       in  8  current axis byte
//   neg/pos   in  1  left/up and right/down buttons of the snapshot
//   analog_en in  1  0 = hold centre
//   nxt       out 8  axis byte after this update
module joypad_axis_slew
  import joypad_pkg::*;
#(
  parameter logic [7:0] STEP = 8'h20
) (
  input  logic [7:0] cur,
  input  logic       neg,
  input  logic       pos,
  input  logic       analog_en,
  output logic [7:0] nxt
);

  logic [7:0] tgt;
  logic [8:0] cur9;
  logic [8:0] tgt9;
  logic [8:0] step9;

  always_comb begin
    tgt   = axis_target(neg, pos);
    cur9  = {1'b0, cur};
    tgt9  = {1'b0, tgt};
    step9 = {1'b0, STEP};
    nxt   = tgt;
    // Distances are taken in 9 bits and a full step is only applied when it
    // cannot reach the target, so cur +/- STEP never wraps past 00/FF.
    if (!analog_en) begin
      nxt = JOY_CENTER;
    end else if (tgt9 > cur9) begin
      if ((tgt9 - cur9) > step9) nxt = cur + STEP;
    end else begin
      if ((cur9 - tgt9) > step9) nxt = cur - STEP;
    end
  end

endmodule

// File: rtl/joypad_tx.sv
// Pad word transmitter: packs buttons and synthesised stick bytes each PERIOD.
// Latency: word appears on out_valid the cycle after the period tick.
// Backpressure: word held until out_ready; a newer snapshot replaces it and
// bumps the saturating overrun_cnt.
//   clk_sys, reset (sync, active-high)
//   btn_in[15:0], pad_type_in[3:0], analog_en   -> pad inputs
//   cont_key[31:0], cont_joy[31:0], out_valid   -> word out, out_ready in
//   overrun_cnt[7:0]                             -> words lost to replacement
module joypad_tx
  import joypad_pkg::*;
#(
  parameter int         PERIOD = 1000,
  parameter logic [7:0] STEP   = 8'h20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] btn_in,
  input  logic [3:0]  pad_type_in,
  input  logic        analog_en,
  output logic [31:0] cont_key,
  output logic [31:0] cont_joy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  overrun_cnt
);

  localparam int            CW       = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      acc_q, acc_d;
  logic [7:0]       lx_q, lx_d, ly_q, ly_d;
  logic [7:0]       lx_nxt, ly_nxt;
  joypad_tx_state_t state_q, state_d;
  logic [31:0]      key_q, key_d;
  logic [31:0]      joy_q, joy_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [15:0]      snap;
  logic             tick;

  // Presses seen at any point since the last tick are folded in, so a
  // single-cycle press between ticks still reaches the next word.
  assign snap = acc_q | btn_in;
  assign tick = (cnt_q == CNT_LAST);

  joypad_axis_slew #(.STEP(STEP)) u_lx (
    .cur       (lx_q),
    .neg       (snap[KEY_LEFT]),
    .pos       (snap[KEY_RIGHT]),
    .analog_en (analog_en),
    .nxt       (lx_nxt)
  );

  joypad_axis_slew #(.STEP(STEP)) u_ly (
    .cur       (ly_q),
    .neg       (snap[KEY_UP]),
    .pos       (snap[KEY_DOWN]),
    .analog_en (analog_en),
    .nxt       (ly_nxt)
  );

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    acc_d   = tick ? '0 : snap;
    lx_d    = tick ? lx_nxt : lx_q;
    ly_d    = tick ? ly_nxt : ly_q;
    state_d = state_q;
    key_d   = key_q;
    joy_d   = joy_q;
    ovr_d   = ovr_q;
    if (tick) begin
      // A tick always wins: accepting and replacing in the same cycle is a
      // clean hand-off, only an unaccepted replacement counts as an overrun.
      state_d = TX_PEND;
      key_d   = {pad_type_in, 12'h000, snap};
      joy_d   = {JOY_CENTER, JOY_CENTER, ly_nxt, lx_nxt};
      if (state_q == TX_PEND && !out_ready && ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end else if (state_q == TX_PEND && out_ready) begin
      state_d = TX_IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      lx_q    <= JOY_CENTER;
      ly_q    <= JOY_CENTER;
      state_q <= TX_IDLE;
      key_q   <= '0;
      joy_q   <= {4{JOY_CENTER}};
      ovr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      state_q <= state_d;
      key_q   <= key_d;
      joy_q   <= joy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cont_key    = key_q;
  assign cont_joy    = joy_q;
  assign out_valid   = (state_q == TX_PEND);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_joypad_tx.sv
module tb_joypad_tx;

  localparam int P    = 4;
  localparam int STEP = 32;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] btn_in = '0;
  logic [3:0]  pad_type_in = '0;
  logic        analog_en = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] cont_key;
  logic [31:0] cont_joy;
  logic        out_valid;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;

  joypad_tx #(.PERIOD(P), .STEP(8'h20)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .btn_in      (btn_in),
    .pad_type_in (pad_type_in),
    .analog_en   (analog_en),
    .cont_key    (cont_key),
    .cont_joy    (cont_joy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural model ----------------
  bit          m_known = 0;
  int          m_cyc;       // cycles since reset released
  logic [15:0] m_acc;       // buttons seen since last snapshot
  logic [15:0] m_snap;
  bit          m_pend;
  int          m_ov;
  int          m_lx;
  int          m_ly;
  logic [31:0] m_key;
  logic [31:0] m_joy;

  function automatic int axis(input int cur, input bit neg, input bit pos, input bit en);
    int tgt;
    if (!en) return 128;
    if (neg == pos) tgt = 128;
    else if (neg)   tgt = 0;
    else            tgt = 255;
    if (tgt - cur > STEP) return cur + STEP;
    if (cur - tgt > STEP) return cur - STEP;
    return tgt;
  endfunction

  initial forever begin
    @(posedge clk_sys);
    if (reset) begin
      m_known = 1;
      m_cyc   = 0;
      m_acc   = '0;
      m_pend  = 0;
      m_ov    = 0;
      m_lx    = 128;
      m_ly    = 128;
      m_key   = '0;
    end else begin
      m_snap = m_acc | btn_in;
      if (m_cyc % P == P - 1) begin
        m_lx = axis(m_lx, m_snap[2], m_snap[3], analog_en);
        m_ly = axis(m_ly, m_snap[0], m_snap[1], analog_en);
        if (m_pend && !out_ready && m_ov < 255) m_ov = m_ov + 1;
        m_pend = 1;
        m_key  = {pad_type_in, 12'h000, m_snap};
        m_acc  = '0;
      end else begin
        m_acc = m_snap;
        if (m_pend && out_ready) m_pend = 0;
      end
      m_cyc = m_cyc + 1;
    end
    m_joy = {16'h8080, m_ly[7:0], m_lx[7:0]};
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk_sys);
    if (m_known) begin
      checks = checks + 1;
      if (out_valid !== m_pend || cont_key !== m_key || cont_joy !== m_joy ||
          overrun_cnt !== 8'(m_ov)) begin
        errors = errors + 1;
        $display("FAIL model_cmp t=%0t: valid %b key %h joy %h ovr %0d, model wants valid %b key %h joy %h ovr %0d",
                 $time, out_valid, cont_key, cont_joy, overrun_cnt, m_pend, m_key, m_joy, m_ov);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge of the next cycle showing out_valid.
  task automatic next_word(output logic [31:0] key, output logic [31:0] joy);
    bit found;
    found = 0;
    key = '0;
    joy = '0;
    @(posedge clk_sys);
    for (int i = 0; i < 3 * P && !found; i++) begin
      @(negedge clk_sys);
      if (out_valid === 1'b1) begin
        found = 1;
        key = cont_key;
        joy = cont_joy;
      end
    end
    if (!found) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL next_word: no out_valid within %0d cycles", 3 * P);
    end
  endtask

  logic [31:0] k, j;
  logic [7:0]  lx_up [5] = '{8'hA0, 8'hC0, 8'hE0, 8'hFF, 8'hFF};
  logic [7:0]  lx_dn [4] = '{8'hDF, 8'hBF, 8'h9F, 8'h80};

  initial begin
    // 1: reset values and first-word latency
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_key", cont_key, 32'h0000_0000);
    chk("rst_joy", cont_joy, 32'h8080_8080);
    chk("rst_ovr", {24'b0, overrun_cnt}, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("first_valid_early", {31'b0, out_valid}, 32'h0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("first_valid", {31'b0, out_valid}, 32'h1);
    chk("first_key", cont_key, 32'h0000_0000);
    chk("first_joy", cont_joy, 32'h8080_8080);
    pad_type_in = 4'h3;

    // 2: one-cycle A press mid-period is kept, then cleared
    @(posedge clk_sys); #1 btn_in = 16'h0010;
    @(posedge clk_sys); #1 btn_in = 16'h0000;
    next_word(k, j);
    chk("pulse_key", k, 32'h3000_0010);
    next_word(k, j);
    chk("pulse_clear_key", k, 32'h3000_0000);

    // 3: right held with analog enabled, then released
    analog_en = 1'b1;
    btn_in = 16'h0008;
    for (int i = 0; i < 5; i++) begin
      next_word(k, j);
      chk($sformatf("lx_up%0d", i), {24'b0, j[7:0]}, {24'b0, lx_up[i]});
      if (i == 0) chk("joy_first_right", j, 32'h8080_80A0);
    end
    btn_in = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      next_word(k, j);
      chk($sformatf("lx_dn%0d", i), {24'b0, j[7:0]}, {24'b0, lx_dn[i]});
    end

    // 4: out_ready low across 3 ticks
    @(posedge clk_sys); #1 out_ready = 1'b0;
    repeat (7) @(posedge clk_sys);
    #1 btn_in = 16'h0020;
    @(posedge clk_sys); #1 btn_in = 16'h0000;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("ovr_valid", {31'b0, out_valid}, 32'h1);
    chk("ovr_cnt2", {24'b0, overrun_cnt}, 32'h2);
    chk("ovr_key", cont_key, 32'h3000_0020);

    // 5: accept in the same cycle as a tick
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1 out_ready = 1'b1; btn_in = 16'h0040;
    @(posedge clk_sys); #1 out_ready = 1'b0; btn_in = 16'h0000;
    @(negedge clk_sys);
    chk("same_tick_valid", {31'b0, out_valid}, 32'h1);
    chk("same_tick_key", cont_key, 32'h3000_0040);
    chk("same_tick_ovr", {24'b0, overrun_cnt}, 32'h2);

    // 4b: saturation
    repeat (300 * P) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("ovr_sat", {24'b0, overrun_cnt}, 32'hFF);

    // 6: reset while pending with lx = C0
    btn_in = 16'h0008;
    repeat (2 * P) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("pre_rst_lx", {24'b0, cont_joy[7:0]}, 32'hC0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_joy", cont_joy, 32'h8080_8080);
    chk("mid_rst_ovr", {24'b0, overrun_cnt}, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("post_rst_early", {31'b0, out_valid}, 32'h0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
    chk("post_rst_key", cont_key, 32'h3000_0008);
    chk("post_rst_joy", cont_joy, 32'h8080_80A0);
    chk("post_rst_ovr", {24'b0, overrun_cnt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
